sram_arbiter_2p: RTL and testbench

Two-requester arbiter and sequencer for one single-port behavioural SRAM macro (`sim_sram_*` family pin set). It accepts read and write commands from two independent valid/ready requesters, picks one per cycle, registers the winning command onto the SRAM pins and returns read data to the owning requester with a fixed latency. It sits between the SCuM-V digital requesters (for example, a DMA master and a debug port) and a shared data SRAM instance.

---
 rtl/sram_arbiter_2p.sv | 160 ++++++++++++++++
 tb/tb_sram_arbiter_2p.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_2p.sv
// sram_arbiter_2p
// Two-requester arbiter and sequencer for a single-port sim_sram_* macro.
// Each cycle one valid command is picked, registered onto the SRAM pins,
// and read data comes back to its owner two edges after acceptance.
//
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between the two requesters on contention
//   undefined -> fixed priority, requester 0 wins ties
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            command handshake for requester N (N=0,1)
//   reqN_we/addr/wdata/wmask    command fields (wmask active-high per bit)
//   respN_valid/rdata           one-cycle read-data strobe and data
//   sram_adr/din/q/ren/wen/wbeb macro data path (wbeb active-low)
//   sram_mcen..sram_clkbyp      macro test/margin pins, tied to zero
module sram_arbiter_2p #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_adr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  sram_ren,
    output logic                  sram_wen,
    output logic [DATA_WIDTH-1:0] sram_wbeb,
    output logic                  sram_mcen,
    output logic [2:0]            sram_mc,
    output logic [1:0]            sram_wa,
    output logic [1:0]            sram_wpulse,
    output logic                  sram_wpulseen,
    output logic                  sram_fwen,
    output logic                  sram_clkbyp
);

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  sel_owner;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] sel_wmask;
    logic                  cmd_owner;
    logic                  rsp_valid;
    logic                  rsp_owner;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    // The pointer names the preferred requester; after a contended cycle
    // it moves to the loser, so the loser is preferred next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (req0_valid && req1_valid) begin
            rr_ptr <= grant0;
        end
    end
`endif

    // Grant is gated by rst_n so ready stays low while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;

    // Grants are one-hot, so requester 1's fields are selected only when it won.
    always_comb begin
        sel_owner = grant1;
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        sel_wmask = grant1 ? req1_wmask : req0_wmask;
    end

    // Command stage drives the macro pins directly; address, data and mask
    // hold their previous values on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ren  <= 1'b0;
            sram_wen  <= 1'b0;
            sram_adr  <= '0;
            sram_din  <= '0;
            sram_wbeb <= '1;
            cmd_owner <= 1'b0;
        end else begin
            sram_ren <= accept && !sel_we;
            sram_wen <= accept && sel_we;
            if (accept) begin
                sram_adr  <= sel_addr;
                sram_din  <= sel_wdata;
                sram_wbeb <= ~sel_wmask;
                cmd_owner <= sel_owner;
            end
        end
    end

    // Response stage tracks a read while the macro produces q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
        end else begin
            rsp_valid <= sram_ren;
            if (sram_ren) begin
                rsp_owner <= cmd_owner;
            end
        end
    end

    assign resp0_valid = rsp_valid && !rsp_owner;
    assign resp1_valid = rsp_valid && rsp_owner;
    assign resp0_rdata = sram_q;
    assign resp1_rdata = sram_q;

    assign sram_mcen     = 1'b0;
    assign sram_mc       = 3'b000;
    assign sram_wa       = 2'b00;
    assign sram_wpulse   = 2'b00;
    assign sram_wpulseen = 1'b0;
    assign sram_fwen     = 1'b0;
    assign sram_clkbyp   = 1'b0;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// tb_sram_arbiter_2p
// Directed bench for sram_arbiter_2p with a behavioural SRAM macro model,
// a shadow memory for expected data, and a response scoreboard queue.
// Follows SRAM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_sram_arbiter_2p;
    localparam int AW = 10;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_wmask;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_wmask;
    logic          resp0_valid, resp1_valid;
    logic [DW-1:0] resp0_rdata, resp1_rdata;
    logic [AW-1:0] sram_adr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_q = '0;
    logic          sram_ren, sram_wen;
    logic [DW-1:0] sram_wbeb;
    logic          sram_mcen;
    logic [2:0]    sram_mc;
    logic [1:0]    sram_wa, sram_wpulse;
    logic          sram_wpulseen, sram_fwen, sram_clkbyp;

    always #5 clk = ~clk;

    sram_arbiter_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .sram_adr(sram_adr), .sram_din(sram_din), .sram_q(sram_q),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_wbeb(sram_wbeb),
        .sram_mcen(sram_mcen), .sram_mc(sram_mc), .sram_wa(sram_wa),
        .sram_wpulse(sram_wpulse), .sram_wpulseen(sram_wpulseen),
        .sram_fwen(sram_fwen), .sram_clkbyp(sram_clkbyp)
    );

    // Behavioural single-port macro: captures on the rising edge, q registered.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_wen) mem[sram_adr] <= (mem[sram_adr] & sram_wbeb) | (sram_din & ~sram_wbeb);
        if (sram_ren) sram_q <= mem[sram_adr];
    end

    typedef struct {
        int            due;
        logic          owner;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            compare_count = 0;
    int            mismatch_count = 0;
    int            step = 0;
    logic          rr_ptr_model = 1'b0;
    logic          exp_ren = 1'b0, exp_wen = 1'b0;
    logic [AW-1:0] exp_adr = '0;
    logic [DW-1:0] exp_din = '0;
    logic [DW-1:0] exp_wbeb = '1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            mismatch_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (step %0d)", tag, observed, expected, step);
        end
    endtask

    task automatic checkPins();
        checkOutput("sram_ren", 64'(sram_ren), 64'(exp_ren));
        checkOutput("sram_wen", 64'(sram_wen), 64'(exp_wen));
        checkOutput("sram_adr", 64'(sram_adr), 64'(exp_adr));
        checkOutput("sram_din", sram_din, exp_din);
        checkOutput("sram_wbeb", sram_wbeb, exp_wbeb);
    endtask

    task automatic checkResponses();
        exp_t e;
        if (resp0_valid === 1'b1 || resp1_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checkOutput("resp_unexpected", 64'({resp1_valid, resp0_valid}), 64'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("resp_latency", 64'(step), 64'(e.due));
                checkOutput("resp_owner", 64'({resp1_valid, resp0_valid}), e.owner ? 64'd2 : 64'd1);
                checkOutput("resp_rdata", e.owner ? resp1_rdata : resp0_rdata, e.data);
            end
        end else if (sbq.size() != 0 && sbq[0].due <= step) begin
            e = sbq.pop_front();
            checkOutput("resp_missing", 64'({resp1_valid, resp0_valid}), e.owner ? 64'd2 : 64'd1);
        end
    endtask

    task automatic acceptCommand(input logic owner, input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [DW-1:0] m);
        exp_t e;
        exp_adr  = a;
        exp_din  = d;
        exp_wbeb = ~m;
        if (we) begin
            exp_wen   = 1'b1;
            shadow[a] = (shadow[a] & ~m) | (d & m);
        end else begin
            exp_ren = 1'b1;
            e.due   = step + 2;
            e.owner = owner;
            e.data  = shadow[a];
            sbq.push_back(e);
        end
    endtask

    // One cycle: check outputs from the previous cycle, drive new inputs,
    // check ready against the arbitration model, and record the accepted command.
    task automatic applyStimulus(
        input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic [DW-1:0] m0,
        input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [DW-1:0] m1);
        logic g0, g1;
        @(negedge clk);
        step++;
        checkPins();
        checkResponses();
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0; req0_wmask = m0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1; req1_wmask = m1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            if (v0 && v1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                g0 = !rr_ptr_model;
                g1 = rr_ptr_model;
                rr_ptr_model = g0 ? 1'b1 : 1'b0;
`else
                g0 = 1'b1;
`endif
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        checkOutput("req0_ready", 64'(req0_ready), 64'(g0));
        checkOutput("req1_ready", 64'(req1_ready), 64'(g1));
        exp_ren = 1'b0;
        exp_wen = 1'b0;
        if (g0) acceptCommand(1'b0, we0, a0, d0, m0);
        else if (g1) acceptCommand(1'b1, we1, a1, d1, m1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    // Asserts reset mid-operation with both requesters valid, checks the
    // immediate reset values, holds for a few cycles, then releases.
    task automatic pulseReset(input int hold);
        @(negedge clk);
        step++;
        checkPins();
        checkResponses();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0;
        sbq.delete();
        rr_ptr_model = 1'b0;
        exp_ren = 1'b0; exp_wen = 1'b0; exp_adr = '0; exp_din = '0; exp_wbeb = '1;
        #1;
        checkPins();
        checkOutput("rst_req0_ready", 64'(req0_ready), 64'd0);
        checkOutput("rst_req1_ready", 64'(req1_ready), 64'd0);
        checkOutput("rst_resp0_valid", 64'(resp0_valid), 64'd0);
        checkOutput("rst_resp1_valid", 64'(resp1_valid), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            step++;
            checkPins();
            checkResponses();
        end
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    localparam logic [DW-1:0] ONES = '1;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;

        // Reset values
        @(negedge clk);
        step++;
        checkPins();
        checkOutput("reset_resp0_valid", 64'(resp0_valid), 64'd0);
        checkOutput("reset_resp1_valid", 64'(resp1_valid), 64'd0);
        checkOutput("tie_pins", 64'({sram_mcen, sram_mc, sram_wa, sram_wpulse, sram_wpulseen, sram_fwen, sram_clkbyp}), 64'd0);
        rst_n = 1'b1;

        $display("[TB] single write/read");
        applyStimulus(1, 1, 10'h005, 64'hDEAD_BEEF_0123_4567, ONES, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 10'h005, '0, '0, 0, 0, '0, '0, '0);
        idle(3);

        $display("[TB] partial mask");
        applyStimulus(1, 1, 10'h010, ONES, ONES, 0, 0, '0, '0, '0);
        applyStimulus(1, 1, 10'h010, 64'h0, 64'h0000_0000_FFFF_0000, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 10'h010, '0, '0, 0, 0, '0, '0, '0);
        idle(3);

        $display("[TB] contention");
        applyStimulus(0, 0, '0, '0, '0, 1, 1, 10'h020, 64'h1122_3344_5566_7788, ONES);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 10'h005, '0, '0, 1, 0, 10'h020, '0, '0);
        end
        idle(3);

        $display("[TB] write-then-read hazard");
        applyStimulus(0, 0, '0, '0, '0, 1, 1, 10'h3FF, 64'hA5A5_A5A5_A5A5_A5A5, ONES);
        applyStimulus(1, 0, 10'h3FF, '0, '0, 0, 0, '0, '0, '0);
        idle(3);

        $display("[TB] idle");
        idle(5);

        $display("[TB] reset mid-flight");
        applyStimulus(1, 0, 10'h010, '0, '0, 0, 0, '0, '0, '0);
        pulseReset(2);
        idle(4);
        applyStimulus(1, 0, 10'h005, '0, '0, 0, 0, '0, '0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 0, 10'h3FF, '0, '0);
        applyStimulus(1, 0, 10'h010, '0, '0, 0, 0, '0, '0, '0);
        idle(4);

        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
